fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage with PC register, instruction-memory request/acknowledge handshake, and IF/ID output register. It sits directly upstream of the control decoder and feeds it opcode and funct fields. It also consumes resolved branch and jump control from later in the pipe, evaluates the branch condition, and redirects the PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk_i` in 1: sole clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: byte address, word-aligned.
- `imem_ack_i` in 1: data valid, one-cycle pulse, variable latency of 1 or more cycles.
- `imem_data_i` in 32: instruction word.
- `instr_valid_o` out 1: IF/ID register holds a valid instruction.
- `instr_ready_i` in 1: decoder/ID stage accepts the instruction.
- `instr_o` out 32: instruction; [31:26] drives decoder op, [5:0] drives funct.
- `pc_plus4_o` out 32: PC+4 of `instr_o`.
- `res_valid_i` in 1: resolve bundle valid for one cycle.
- `res_branch_i` in 1: branch instruction.
- `res_branch_type_i` in 3: 000 beq, 001 ble, 010 bne, 011 bltz.
- `res_jump_i` in 2: 00 none, 01 j/jal, 10 jr, 11 treated as none.
- `res_rs_i`, `res_rt_i` in 32: operand values.
- `res_pc_plus4_i` in 32: PC+4 of the resolving instruction.
- `res_imm_i` in 32: sign-extended 16-bit offset.
- `res_jidx_i` in 26: jump index.
- `redirect_o` out 1: one-cycle pulse when a redirect is taken; used by downstream stages to flush.

## Operation
- States: IDLE, FETCH, WAIT_DROP, HOLD.
- IDLE:
  - Entered after reset.
  - Next cycle moves to FETCH.
- FETCH:
  - `imem_req_o`=1 and `imem_addr_o`=pc.
  - On `imem_ack_i`: load `instr_o`=`imem_data_i` and `pc_plus4_o`=pc+4, set `instr_valid_o`=1, set pc=pc+4, go to HOLD.
- HOLD:
  - Handshake fires when `instr_valid_o` and `instr_ready_i` are both 1.
  - If no redirect: go to FETCH and drop `instr_valid_o`. There is one bubble per instruction; no prefetch.
  - Otherwise stay, with outputs stable.
- Redirect is taken when `res_valid_i` and (jump != 00, or branch is taken).
- Redirect effects: set pc=target, pulse `redirect_o`, clear `instr_valid_o` (flush) next cycle.
- Redirect while a FETCH request is outstanding:
  - `imem_req_o` drops.
  - Go to WAIT_DROP; discard the next ack.
  - Then go to FETCH at the target.
  - A further redirect in WAIT_DROP overwrites pc.
- Redirect in HOLD or IDLE: go to FETCH at the target next cycle.
- Priority: redirect over handshake over sequential fetch.
- Jump and branch asserted together: the jump wins.
- Branch-taken rules:
  - beq: rs==rt.
  - bne: rs!=rt.
  - ble: $signed(rs) <= $signed(rt).
  - bltz: $signed(rs) < 0.
  - Other types: not taken.
- Targets:
  - Branch: `res_pc_plus4_i` + (`res_imm_i`<<2), mod 2^32.
  - j: {`res_pc_plus4_i`[31:28], `res_jidx_i`, 2'b00}.
  - jr: `res_rs_i` with [1:0] forced to 00.
- PC increment wraps 32'hFFFF_FFFC to 32'h0000_0000.

## Timing
- Reset values:
  - state=IDLE, pc=`RESET_PC`.
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - `instr_valid_o`=0, `instr_o`=0, `pc_plus4_o`=0, `redirect_o`=0.
- Reset asserted mid-fetch: the pending ack is ignored. After release, the first request goes to `RESET_PC` on cycle 2 (IDLE then FETCH).
- `instr_valid_o` rises the cycle after the ack edge.
- Ack-to-next-request minimum is 2 cycles when `instr_ready_i`=1.
- `redirect_o` is registered: it is high the cycle after `res_valid_i`. The new `imem_addr_o` is visible in that same cycle.
- `imem_ack_i` outside FETCH/WAIT_DROP is ignored.

## Configuration
- `FETCH_EXT_BRANCH_EN`:
  - Defined: ble and bltz are evaluated as above.
  - Undefined: only beq and bne are evaluated; types 001 and 011 are never taken and never redirect.

## Test plan
- Sequential fetch: reset with `RESET_PC`=0, ack latency 1, ready=1 -> `imem_addr_o` 0,4,8,…; `pc_plus4_o` 4,8,12; `instr_o` matches memory.
- Backpressure: `instr_ready_i`=0 for 5 cycles -> `instr_o` and `instr_valid_o` stay stable; no new request; resumes at next PC.
- beq taken: rs=rt=7, pc_plus4=0x20, imm=-2 -> `redirect_o` pulse; next address 0x18; valid instruction flushed.
- Redirect during outstanding fetch (ack latency 3): j with jidx=0x40 -> stale ack discarded; next address 0x100; `instr_o` is never the stale word.
- ble/bltz: rs=-1, rt=0 -> taken with the macro; not taken without it. jr with rs=0x203 -> target 0x200.
- Async reset asserted while in HOLD -> all outputs reach reset values immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Holds the PC, runs the imem request/ack handshake, and presents one instruction
// at a time in the IF/ID register. Fetch is not prefetched, so each instruction
// costs one bubble. Resolved branches and jumps from later in the pipe redirect
// the PC and flush the held instruction.
// Build option: define FETCH_EXT_BRANCH_EN to evaluate ble and bltz. Without it,
// only beq and bne can be taken.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | just out of reset, no request yet
// FETCH     | request to imem_addr_o outstanding, waiting for ack
// WAIT_DROP | request abandoned by a redirect, next ack is discarded
// HOLD      | IF/ID register valid, waiting for the decoder to accept
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  input  logic        res_valid_i,
  input  logic        res_branch_i,
  input  logic [2:0]  res_branch_type_i,
  input  logic [1:0]  res_jump_i,
  input  logic [31:0] res_rs_i,
  input  logic [31:0] res_rt_i,
  input  logic [31:0] res_pc_plus4_i,
  input  logic [31:0] res_imm_i,
  input  logic [25:0] res_jidx_i,
  output logic        redirect_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_WAIT_DROP = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        redirect_q, redirect_d;

  logic        br_taken;
  logic        jump_j;
  logic        jump_r;
  logic        take_redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_inc;

  // Branch condition evaluation for the resolve bundle.
  always_comb begin
    br_taken = 1'b0;
    case (res_branch_type_i)
      3'b000: br_taken = (res_rs_i == res_rt_i);
      3'b010: br_taken = (res_rs_i != res_rt_i);
`ifdef FETCH_EXT_BRANCH_EN
      3'b001: br_taken = ($signed(res_rs_i) <= $signed(res_rt_i));
      3'b011: br_taken = res_rs_i[31];
`endif
      default: br_taken = 1'b0;
    endcase
  end

  // Redirect decision and target; a jump overrides a simultaneous branch.
  always_comb begin
    jump_j        = (res_jump_i == 2'b01);
    jump_r        = (res_jump_i == 2'b10);
    take_redirect = res_valid_i & (jump_j | jump_r | (res_branch_i & br_taken));
    if (jump_j) begin
      redirect_target = {res_pc_plus4_i[31:28], res_jidx_i, 2'b00};
    end else if (jump_r) begin
      redirect_target = {res_rs_i[31:2], 2'b00};
    end else begin
      redirect_target = res_pc_plus4_i + (res_imm_i << 2);
    end
  end

  // Next-state and next-output computation; redirect has top priority.
  always_comb begin
    pc_inc     = pc_q + 32'd4;
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    redirect_d = take_redirect;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_data_i;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = S_HOLD;
        end
      end
      S_WAIT_DROP: begin
        if (imem_ack_i) begin
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (valid_q && instr_ready_i) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_redirect) begin
      // An ack landing in the same cycle is for the old path: keep the IF/ID
      // contents untouched and treat the request as finished.
      pc_d    = redirect_target;
      valid_d = 1'b0;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      if ((state_q == S_FETCH || state_q == S_WAIT_DROP) && !imem_ack_i) begin
        state_d = S_WAIT_DROP;
      end else begin
        state_d = S_FETCH;
      end
    end

    req_d  = (state_d == S_FETCH);
    addr_d = pc_d;
  end

  // Single register bank for state, PC and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc4_q      <= 32'h0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      redirect_q <= redirect_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_plus4_o    = pc4_q;
  assign redirect_o    = redirect_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// A memory responder with random latency feeds the DUT; the reference model
// tracks the next expected fetch address, the instructions that should reach
// the decoder, and the redirects that should fire.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_EXT_BRANCH_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        res_valid_i;
  logic        res_branch_i;
  logic [2:0]  res_branch_type_i;
  logic [1:0]  res_jump_i;
  logic [31:0] res_rs_i;
  logic [31:0] res_rt_i;
  logic [31:0] res_pc_plus4_i;
  logic [31:0] res_imm_i;
  logic [25:0] res_jidx_i;
  logic        redirect_o;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_plus4_o(pc_plus4_o),
    .res_valid_i(res_valid_i), .res_branch_i(res_branch_i),
    .res_branch_type_i(res_branch_type_i), .res_jump_i(res_jump_i),
    .res_rs_i(res_rs_i), .res_rt_i(res_rt_i),
    .res_pc_plus4_i(res_pc_plus4_i), .res_imm_i(res_imm_i),
    .res_jidx_i(res_jidx_i), .redirect_o(redirect_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } item_t;

  typedef struct {
    logic [31:0] target;
    int unsigned due;
  } redir_t;

  typedef struct {
    int          mode;  // 0: issue while holding, 1: issue while fetch outstanding
    logic        br;
    logic [2:0]  bt;
    logic [1:0]  jp;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [25:0] jidx;
  } dir_t;

  item_t       exp_q[$];
  redir_t      redir_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;

  logic [31:0] model_next;
  logic [31:0] mem_addr;
  bit          mem_busy;
  bit          mem_stale;
  int          mem_cnt;
  int          lat_min;
  int          lat_max;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference rules for the resolve bundle, in plain arithmetic.
  function automatic void ref_resolve(input logic br, input logic [2:0] bt, input logic [1:0] jp,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [31:0] pc4, input logic [31:0] imm,
                                      input logic [25:0] jidx,
                                      output bit taken, output logic [31:0] tgt);
    bit cond;
    bit is_jump;
    cond = 1'b0;
    if (bt == 3'd0) cond = (rs == rt);
    else if (bt == 3'd2) cond = (rs != rt);
    else if (bt == 3'd1) cond = EXT && ($signed(rs) <= $signed(rt));
    else if (bt == 3'd3) cond = EXT && ($signed(rs) < 0);
    is_jump = (jp == 2'd1) || (jp == 2'd2);
    taken = is_jump || (br && cond);
    if (jp == 2'd1) tgt = (pc4 & 32'hF000_0000) + ({6'd0, jidx} * 32'd4);
    else if (jp == 2'd2) tgt = rs - (rs % 32'd4);
    else tgt = pc4 + imm * 32'd4;
  endfunction

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic issue(input logic br, input logic [2:0] bt, input logic [1:0] jp,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc4,
                       input logic [31:0] imm, input logic [25:0] jidx);
    bit          taken;
    logic [31:0] tgt;
    res_valid_i       = 1'b1;
    res_branch_i      = br;
    res_branch_type_i = bt;
    res_jump_i        = jp;
    res_rs_i          = rs;
    res_rt_i          = rt;
    res_pc_plus4_i    = pc4;
    res_imm_i         = imm;
    res_jidx_i        = jidx;
    instr_ready_i     = 1'b0;
    ref_resolve(br, bt, jp, rs, rt, pc4, imm, jidx, taken, tgt);
    if (taken) begin
      redir_q.push_back('{target: tgt, due: cyc + 1});
      model_next = tgt;
      exp_q.delete();
      if (mem_busy) mem_stale = 1'b1;
    end
    step();
    res_valid_i = 1'b0;
  endtask

  // which 0: IF/ID valid; which 1: fetch outstanding with ack at least 2 cycles away
  task automatic wait_for(input int which);
    for (int i = 0; i < 60; i++) begin
      if (which == 0 && instr_valid_o) return;
      if (which == 1 && imem_req_o && mem_busy && mem_cnt >= 2) return;
      step();
    end
    fail_now("wait_timeout", 32'(which), 32'hFFFF_FFFF);
  endtask

  // Instruction memory responder.
  initial begin
    imem_ack_i  = 1'b0;
    imem_data_i = 32'h0;
    mem_busy    = 1'b0;
    mem_stale   = 1'b0;
    mem_cnt     = 0;
    mem_addr    = 32'h0;
    forever begin
      @(negedge clk_i);
      imem_ack_i = 1'b0;
      if (!rst_i) begin
        mem_busy = 1'b0;
      end else begin
        if (!mem_busy && imem_req_o) begin
          check("req_addr", imem_addr_o, model_next);
          mem_addr  = imem_addr_o;
          mem_busy  = 1'b1;
          mem_stale = 1'b0;
          mem_cnt   = int'($urandom_range(lat_max, lat_min));
        end
        if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_ack_i  = 1'b1;
            imem_data_i = mem_word(mem_addr);
            mem_busy    = 1'b0;
            if (!mem_stale) begin
              exp_q.push_back('{instr: mem_word(mem_addr), pc4: mem_addr + 32'd4});
              model_next = mem_addr + 32'd4;
            end
          end
        end
      end
    end
  end

  // Monitor: compares delivered instructions and redirect pulses.
  initial begin
    item_t  it;
    redir_t rd;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        if (instr_valid_o && instr_ready_i) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_instr", instr_o, 32'h0);
          end else begin
            it = exp_q.pop_front();
            check("instr_o", instr_o, it.instr);
            check("pc_plus4_o", pc_plus4_o, it.pc4);
          end
        end
        if (redirect_o) begin
          if (redir_q.size() == 0 || redir_q[0].due != cyc) begin
            fail_now("unexpected_redirect", imem_addr_o, 32'h0);
            if (redir_q.size() != 0) void'(redir_q.pop_front());
          end else begin
            rd = redir_q.pop_front();
            check("redirect_addr", imem_addr_o, rd.target);
            check("flush_valid", 32'(instr_valid_o), 32'h0);
          end
        end else if (redir_q.size() != 0 && redir_q[0].due <= cyc) begin
          rd = redir_q.pop_front();
          fail_now("missing_redirect", 32'h0, rd.target);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    dir_t        dirs[9];
    logic [31:0] rs;
    logic [31:0] pc4;
    logic [15:0] i16;

    dirs[0] = '{0, 1'b1, 3'd0, 2'd0, 32'd7, 32'd7, 32'h20, 32'hFFFF_FFFE, 26'd0};
    dirs[1] = '{1, 1'b0, 3'd0, 2'd1, 32'd0, 32'd0, 32'h24, 32'd0, 26'h40};
    dirs[2] = '{0, 1'b1, 3'd1, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'd8, 26'd0};
    dirs[3] = '{0, 1'b1, 3'd3, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'h200, 32'd4, 26'd0};
    dirs[4] = '{1, 1'b0, 3'd0, 2'd2, 32'h203, 32'd0, 32'h0, 32'd0, 26'd0};
    dirs[5] = '{0, 1'b1, 3'd2, 2'd0, 32'd5, 32'd5, 32'h300, 32'd4, 26'd0};
    dirs[6] = '{0, 1'b1, 3'd0, 2'd1, 32'd9, 32'd9, 32'h40, 32'd1, 26'h80};
    dirs[7] = '{0, 1'b0, 3'd0, 2'd2, 32'hFFFF_FFF9, 32'd0, 32'h0, 32'd0, 26'd0};
    dirs[8] = '{0, 1'b0, 3'd0, 2'd3, 32'd0, 32'd0, 32'h500, 32'd0, 26'h11};

    rst_i = 1'b1;
    instr_ready_i = 1'b0;
    res_valid_i = 1'b0; res_branch_i = 1'b0; res_branch_type_i = 3'd0; res_jump_i = 2'd0;
    res_rs_i = 32'h0; res_rt_i = 32'h0; res_pc_plus4_i = 32'h0; res_imm_i = 32'h0;
    res_jidx_i = 26'h0;
    model_next = RST_PC;
    lat_min = 1;
    lat_max = 1;

    #1 rst_i = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_addr", imem_addr_o, RST_PC);
    check("rst_valid", 32'(instr_valid_o), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc4", pc_plus4_o, 32'h0);
    check("rst_redirect", 32'(redirect_o), 32'h0);
    step();
    step();
    rst_i = 1'b1;

    // Sequential fetch, latency 1, always ready.
    instr_ready_i = 1'b1;
    repeat (40) step();

    // Backpressure for 5 cycles while holding an instruction.
    instr_ready_i = 1'b0;
    wait_for(0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(instr_valid_o), 32'h1);
      check("bp_no_req", 32'(imem_req_o), 32'h0);
      if (exp_q.size() != 0) check("bp_instr", instr_o, exp_q[0].instr);
      else fail_now("bp_no_expected", instr_o, 32'h0);
      step();
    end
    instr_ready_i = 1'b1;
    repeat (6) step();

    // Directed redirect cases.
    for (int d = 0; d < 9; d++) begin
      if (dirs[d].mode == 1) begin
        lat_min = 3;
        lat_max = 3;
        instr_ready_i = 1'b1;
        wait_for(1);
      end else begin
        instr_ready_i = 1'b0;
        wait_for(0);
      end
      issue(dirs[d].br, dirs[d].bt, dirs[d].jp, dirs[d].rs, dirs[d].rt,
            dirs[d].pc4, dirs[d].imm, dirs[d].jidx);
      lat_min = 1;
      lat_max = 1;
      instr_ready_i = 1'b1;
      repeat (8) step();
    end

    // Randomized traffic.
    lat_min = 1;
    lat_max = 3;
    for (int n = 0; n < 1500; n++) begin
      instr_ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        rs  = $urandom;
        pc4 = $urandom & 32'hFFFF_FFFC;
        i16 = 16'($urandom);
        issue(1'($urandom), 3'($urandom_range(0, 4)),
              ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0,
              rs, ($urandom_range(0, 1) == 0) ? rs : $urandom, pc4,
              {{16{i16[15]}}, i16}, 26'($urandom));
      end else begin
        step();
      end
    end
    instr_ready_i = 1'b1;
    repeat (10) step();

    // Asynchronous reset while holding an instruction.
    instr_ready_i = 1'b0;
    wait_for(0);
    rst_i = 1'b0;
    #1;
    check("hold_rst_req", 32'(imem_req_o), 32'h0);
    check("hold_rst_addr", imem_addr_o, RST_PC);
    check("hold_rst_valid", 32'(instr_valid_o), 32'h0);
    check("hold_rst_instr", instr_o, 32'h0);
    check("hold_rst_pc4", pc_plus4_o, 32'h0);
    check("hold_rst_redirect", 32'(redirect_o), 32'h0);
    exp_q.delete();
    redir_q.delete();
    mem_busy = 1'b0;
    mem_stale = 1'b0;
    model_next = RST_PC;
    step();
    step();
    rst_i = 1'b1;
    instr_ready_i = 1'b1;
    check("post_rst_idle_req", 32'(imem_req_o), 32'h0);
    step();
    check("post_rst_req", 32'(imem_req_o), 32'h1);
    check("post_rst_addr", imem_addr_o, RST_PC);
    repeat (20) step();

    check("redirects_drained", 32'(redir_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
